lcd_nibble_driver: RTL and testbench

LCD_NIBBLE_DRIVER -- requirements
Module: lcd_nibble_driver

---
 rtl/lcd_nibble_driver.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_nibble_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_driver.sv
// 4-bit HD44780 LCD write driver: power-on wait, nibble init, configuration bytes,
// then a valid/ready byte port. Every LCD-facing output is a flop.
module lcd_nibble_driver #(
    parameter int T_PWR  = 750000,
    parameter int T_E    = 12,
    parameter int T_SU   = 2,
    parameter int T_NIB  = 50,
    parameter int T_BYTE = 2000,
    parameter int T_CLR  = 82000,
    parameter int T_I1   = 205000,
    parameter int T_I2   = 5000
) (
    input  logic       clk,
    input  logic       resetbtn,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       sf_e,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic       d,
    output logic       c,
    output logic       b,
    output logic       a
);

    function automatic int max2(int x, int y);
        return (x > y) ? x : y;
    endfunction

    localparam int CMAX = max2(max2(max2(T_PWR, T_I1), max2(T_I2, T_CLR)),
                               max2(max2(T_BYTE, T_NIB), max2(T_E, T_SU)));
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] L_PWR  = CW'(T_PWR - 1);
    localparam logic [CW-1:0] L_E    = CW'(T_E - 1);
    localparam logic [CW-1:0] L_SU   = CW'(T_SU - 1);
    localparam logic [CW-1:0] L_NIB  = CW'(T_NIB - 1);
    localparam logic [CW-1:0] L_BYTE = CW'(T_BYTE - 1);
    localparam logic [CW-1:0] L_CLR  = CW'(T_CLR - 1);
    localparam logic [CW-1:0] L_I1   = CW'(T_I1 - 1);
    localparam logic [CW-1:0] L_I2   = CW'(T_I2 - 1);

    // Configuration bytes reuse the user byte path (SEND_HI..WAIT) with cfg set,
    // so they get exactly the same nibble timing as user writes.
    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_HI, S_GAP, S_LO, S_WAIT, S_IDLE
    } state_t;

    typedef enum logic [1:0] {PH_SU, PH_EH, PH_HD, PH_WT} ph_t;

    function automatic logic [7:0] cfg_byte(logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    state_t          state, state_n;
    ph_t             ph, ph_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      idx, idx_n;
    logic            cfg, cfg_n;
    logic [7:0]      byte_q, byte_n;
    logic            brs_q, brs_n;
    logic [3:0]      nib_q, nib_n;
    logic            rs_q, rs_n;
    logic            e_q, e_n;
    logic            done_n;
    logic            load, load_rs, nib_done;
    logic [7:0]      load_byte;
    logic [CW-1:0]   init_lim, wait_lim;

    always_comb begin
        case (idx)
            2'd0:    init_lim = L_I1;
            2'd1:    init_lim = L_I2;
            default: init_lim = L_BYTE;
        endcase
        wait_lim = (!brs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ? L_CLR : L_BYTE;
    end

    always_comb begin
        state_n   = state;
        ph_n      = ph;
        cnt_n     = cnt + 1'b1;
        idx_n     = idx;
        cfg_n     = cfg;
        byte_n    = byte_q;
        brs_n     = brs_q;
        nib_n     = nib_q;
        rs_n      = rs_q;
        done_n    = init_done;
        load      = 1'b0;
        load_byte = 8'h00;
        load_rs   = 1'b0;
        nib_done  = 1'b0;

        // setup -> E high -> one hold cycle, shared by every nibble
        if (state == S_INIT || state == S_HI || state == S_LO) begin
            case (ph)
                PH_SU:   if (cnt == L_SU) begin ph_n = PH_EH; cnt_n = '0; end
                PH_EH:   if (cnt == L_E)  begin ph_n = PH_HD; cnt_n = '0; end
                PH_HD:   nib_done = 1'b1;
                default: ;
            endcase
        end

        case (state)
            S_PWR: begin
                if (cnt == L_PWR) begin
                    state_n = S_INIT;
                    ph_n    = PH_SU;
                    cnt_n   = '0;
                    nib_n   = 4'h3;
                    rs_n    = 1'b0;
                    idx_n   = '0;
                end
            end
            S_INIT: begin
                if (nib_done) begin
                    ph_n  = PH_WT;
                    cnt_n = '0;
                end else if (ph == PH_WT && cnt == init_lim) begin
                    cnt_n = '0;
                    if (idx == 2'd3) begin
                        cfg_n     = 1'b1;
                        idx_n     = '0;
                        load      = 1'b1;
                        load_byte = cfg_byte(2'd0);
                    end else begin
                        idx_n = idx + 2'd1;
                        ph_n  = PH_SU;
                        nib_n = (idx == 2'd2) ? 4'h2 : 4'h3;
                    end
                end
            end
            S_HI: begin
                if (nib_done) begin state_n = S_GAP; cnt_n = '0; end
            end
            S_GAP: begin
                if (cnt == L_NIB) begin
                    state_n = S_LO;
                    ph_n    = PH_SU;
                    cnt_n   = '0;
                    nib_n   = byte_q[3:0];
                end
            end
            S_LO: begin
                if (nib_done) begin state_n = S_WAIT; cnt_n = '0; end
            end
            S_WAIT: begin
                if (cnt == wait_lim) begin
                    cnt_n = '0;
                    if (cfg && idx != 2'd3) begin
                        idx_n     = idx + 2'd1;
                        load      = 1'b1;
                        load_byte = cfg_byte(idx + 2'd1);
                    end else begin
                        state_n = S_IDLE;
                        cfg_n   = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                cnt_n = '0;
                if (wr_valid) begin
                    load      = 1'b1;
                    load_byte = wr_data;
                    load_rs   = wr_rs;
                end
            end
            default: state_n = S_PWR;
        endcase

        if (load) begin
            state_n = S_HI;
            ph_n    = PH_SU;
            cnt_n   = '0;
            byte_n  = load_byte;
            brs_n   = load_rs;
            nib_n   = load_byte[7:4];
            rs_n    = load_rs;
        end

        e_n = (ph_n == PH_EH) && (state_n == S_INIT || state_n == S_HI || state_n == S_LO);
    end

    always_ff @(posedge clk) begin
        if (!resetbtn) begin
            state     <= S_PWR;
            ph        <= PH_SU;
            cnt       <= '0;
            idx       <= '0;
            cfg       <= 1'b0;
            byte_q    <= '0;
            brs_q     <= 1'b0;
            nib_q     <= '0;
            rs_q      <= 1'b0;
            e_q       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            ph        <= ph_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            cfg       <= cfg_n;
            byte_q    <= byte_n;
            brs_q     <= brs_n;
            nib_q     <= nib_n;
            rs_q      <= rs_n;
            e_q       <= e_n;
            init_done <= done_n;
        end
    end

    assign wr_ready     = (state == S_IDLE) && init_done;
    assign e            = e_q;
    assign rs           = rs_q;
    assign {d, c, b, a} = nib_q;
    assign rw           = 1'b0;
    assign sf_e         = 1'b1;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Directed bench for lcd_nibble_driver with short timing parameters; expected
// nibbles and cycle spacings are hand-derived from the timing parameters.
module tb_lcd_nibble_driver;

    localparam int T_PWR = 20, T_E = 3, T_SU = 2, T_NIB = 4;
    localparam int T_BYTE = 10, T_CLR = 30, T_I1 = 15, T_I2 = 8;

    logic       clk = 1'b0;
    logic       resetbtn = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, sf_e, e, rs, rw, d, c, b, a;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int static_bad = 0;

    // init nibbles then config bytes 28/06/0C/01; spacing is rise-to-rise
    // (first entry measured from reset release)
    logic [3:0] exp_n [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    int         exp_d [12] = '{22, 21, 14, 16, 16, 10, 16, 10, 16, 10, 16, 10};

    lcd_nibble_driver #(
        .T_PWR(T_PWR), .T_E(T_E), .T_SU(T_SU), .T_NIB(T_NIB),
        .T_BYTE(T_BYTE), .T_CLR(T_CLR), .T_I1(T_I1), .T_I2(T_I2)
    ) dut (
        .clk(clk), .resetbtn(resetbtn), .wr_valid(wr_valid), .wr_rs(wr_rs),
        .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done), .sf_e(sf_e),
        .e(e), .rs(rs), .rw(rw), .d(d), .c(c), .b(b), .a(a)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sf_e !== 1'b1 || rw !== 1'b0) static_bad <= static_bad + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Returns nibble/rs at the E rise, the cycle of the rise and the high width;
    // leaves the bench on the first sample with e low again.
    task automatic get_pulse(output logic [3:0] n, output logic r, output int rise_t, output int w);
        int k = 0;
        while (e !== 1'b1 && k < 3000) begin step(); k++; end
        check("pulse_seen", e, 1);
        n = {d, c, b, a};
        r = rs;
        rise_t = cyc;
        w = 0;
        while (e === 1'b1 && w < 100) begin step(); w++; end
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (wr_ready !== 1'b1 && k < 200) begin step(); k++; end
        check("ready_seen", wr_ready, 1);
    endtask

    task automatic do_byte(input logic r, input logic [7:0] dat, input int wlen);
        int a0, t1, t2, w;
        logic [3:0] n;
        logic rr;
        wr_valid = 1'b1; wr_rs = r; wr_data = dat;
        step();
        a0 = cyc;
        check("acc_ready_low", wr_ready, 0);
        wr_valid = 1'b0;
        get_pulse(n, rr, t1, w);
        check("hi_nib", n, dat[7:4]);
        check("hi_rs", rr, r);
        check("hi_setup", t1 - a0, T_SU);
        check("hi_width", w, T_E);
        get_pulse(n, rr, t2, w);
        check("lo_nib", n, dat[3:0]);
        check("lo_rs", rr, r);
        check("lo_spacing", t2 - t1, T_E + 1 + T_NIB + T_SU);
        check("lo_width", w, T_E);
        wait_ready(w);
        check("post_wait", w, 1 + wlen);
        check("done_held", init_done, 1);
    endtask

    initial begin
        logic [3:0] n;
        logic rr;
        int t, tp, w, cyc0, k;

        repeat (3) step();
        check("rst_outs", {e, rs, d, c, b, a, wr_ready, init_done}, 0);
        check("rst_sfe_rw", {sf_e, rw}, 2'b10);

        // a request pending through init must not be taken
        resetbtn = 1'b1; wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'hFF;
        cyc0 = cyc;
        repeat (19) step();
        check("pwr_quiet", {e, d, c, b, a, wr_ready}, 0);
        step();
        check("pwr_first_nib", {e, rs, d, c, b, a}, 6'b000011);
        tp = cyc0;
        for (int i = 0; i < 12; i++) begin
            get_pulse(n, rr, t, w);
            check($sformatf("init_nib%0d", i), n, exp_n[i]);
            check($sformatf("init_rs%0d", i), rr, 0);
            check($sformatf("init_width%0d", i), w, T_E);
            check($sformatf("init_spacing%0d", i), t - tp, exp_d[i]);
            tp = t;
        end
        check("pre_done", {init_done, wr_ready}, 0);
        wr_valid = 1'b0;
        wait_ready(w);
        check("cfg_clr_wait", w, 1 + T_CLR);
        check("init_done", init_done, 1);

        do_byte(1'b1, 8'h41, T_BYTE);
        do_byte(1'b0, 8'h01, T_CLR);
        do_byte(1'b0, 8'h02, T_CLR);
        do_byte(1'b1, 8'h01, T_BYTE);
        do_byte(1'b0, 8'h03, T_BYTE);

        // back-to-back with wr_valid held high
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h48;
        step();
        check("b2b_acc1", wr_ready, 0);
        wr_data = 8'h49;
        get_pulse(n, rr, t, w);
        check("b2b_n0", {rr, n}, 5'h14);
        get_pulse(n, rr, tp, w);
        check("b2b_n1", {rr, n}, 5'h18);
        wait_ready(w);
        check("b2b_wait1", w, 1 + T_BYTE);
        step();
        check("b2b_acc2", wr_ready, 0);
        wr_valid = 1'b0;
        get_pulse(n, rr, t, w);
        check("b2b_n2", {rr, n}, 5'h14);
        check("b2b_spacing", t - tp, T_E + 1 + T_BYTE + 1 + T_SU);
        get_pulse(n, rr, t, w);
        check("b2b_n3", {rr, n}, 5'h19);
        wait_ready(w);
        check("b2b_wait2", w, 1 + T_BYTE);

        // reset while E is high
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
        step();
        wr_valid = 1'b0;
        k = 0;
        while (e !== 1'b1 && k < 50) begin step(); k++; end
        check("mid_e_high", e, 1);
        step();
        resetbtn = 1'b0;
        step();
        check("rst_mid_outs", {e, rs, d, c, b, a, wr_ready, init_done}, 0);
        step();
        step();
        check("rst_mid_held", {e, rs, d, c, b, a, wr_ready, init_done}, 0);
        resetbtn = 1'b1;
        cyc0 = cyc;
        repeat (20) step();
        check("restart_nib", {e, rs, d, c, b, a}, 6'b000011);
        get_pulse(n, rr, t, w);
        check("restart_pulse", {rr, n}, 5'h03);
        check("restart_spacing", t - cyc0, 22);
        check("restart_done_low", init_done, 0);

        check("static_sfe_rw", static_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
